frame_collector: RTL and testbench

- Receiving end of the correlator frame-dispatch interface.
- Consumes the periodic frame-boundary pulse produced by the dispatcher control, together with the per-cycle correlator output samples.
- Per frame, accumulates the sample sum, tracks the peak magnitude and its index, counts samples and checks the frame length.
- At each boundary, hands the completed frame's result downstream over a valid/ready handshake.

---
 rtl/corr_pkg.sv | 23 ++
 rtl/peak_tracker.sv | 35 +++
 rtl/frame_collector.sv | 118 +++++++++++
 tb/tb_frame_collector.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared types and defaults for the correlator frame path.
// Used by the frame collector and the peak tracker.
package corr_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_FRAME_LEN = 2048;
  localparam int DEF_CNT_W     = 12;
  localparam int ACC_W         = DEF_DATA_W + DEF_CNT_W;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [ACC_W-1:0]      acc;
    logic [DEF_DATA_W:0]   peak;
    logic [DEF_CNT_W-1:0]  idx;
    logic [DEF_CNT_W:0]    nsamp;
    logic                  len_err;
  } res_t;

endpackage

// File: rtl/peak_tracker.sv
// Magnitude peak search step: |x|, strict compare, index update.
// Ties keep the earliest index; index freezes when i_pos_ok is low.
module peak_tracker
  import corr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic [DATA_W-1:0] i_smp,
  input  logic [DATA_W:0]   i_peak,
  input  logic [CNT_W-1:0]  i_idx,
  input  logic [CNT_W-1:0]  i_pos,
  input  logic              i_pos_ok,
  output logic [DATA_W:0]   o_abs,
  output logic [DATA_W:0]   o_peak,
  output logic [CNT_W-1:0]  o_idx
);

  logic [DATA_W:0] w_ext;
  logic            w_gt;

  // one extra bit so the most negative sample has a representable magnitude
  assign w_ext = {i_smp[DATA_W-1], i_smp};

  // magnitude and strict-greater update
  always_comb begin
    o_abs  = w_ext;
    if (w_ext[DATA_W])
      o_abs = ~w_ext + (DATA_W+1)'(1);
    w_gt   = (o_abs > i_peak);
    o_peak = w_gt ? o_abs : i_peak;
    o_idx  = (w_gt && i_pos_ok) ? i_pos : i_idx;
  end

endmodule

// File: rtl/frame_collector.sv
// Per-frame sum / peak / count collector on the frame_rst boundary.
// Closed frames are handed downstream over a valid/ready port.
module frame_collector
  import corr_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_rst,
  input  logic                    smp_valid,
  input  logic [DATA_W-1:0]       smp_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_W+CNT_W-1:0] res_acc,
  output logic [DATA_W:0]         res_peak,
  output logic [CNT_W-1:0]        res_peak_idx,
  output logic [CNT_W:0]          res_nsamp,
  output logic                    res_len_err,
  output logic                    overrun
);

  localparam int SUM_W = DATA_W + CNT_W;

  state_e             r_state;
  logic [SUM_W-1:0]   r_acc;
  logic [DATA_W:0]    r_peak;
  logic [CNT_W-1:0]   r_idx;
  logic [CNT_W:0]     r_nsamp;
  logic [CNT_W:0]     r_cyc;

  logic [SUM_W-1:0]   w_ext;
  logic [DATA_W:0]    w_abs;
  logic [DATA_W:0]    w_peak;
  logic [CNT_W-1:0]   w_idx;
  logic               w_pos_ok;
  logic               w_close;

  assign w_ext    = {{(SUM_W-DATA_W){smp_data[DATA_W-1]}}, smp_data};
  assign w_pos_ok = ~r_nsamp[CNT_W];
  assign w_close  = frame_rst && (r_state == S_RUN);

  peak_tracker #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_peak (
    .i_smp    (smp_data),
    .i_peak   (r_peak),
    .i_idx    (r_idx),
    .i_pos    (r_nsamp[CNT_W-1:0]),
    .i_pos_ok (w_pos_ok),
    .o_abs    (w_abs),
    .o_peak   (w_peak),
    .o_idx    (w_idx)
  );

  // state machine and running frame registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT;
      r_acc   <= '0;
      r_peak  <= '0;
      r_idx   <= '0;
      r_nsamp <= '0;
      r_cyc   <= '0;
    end else if (frame_rst) begin
      r_state <= S_RUN;
      r_cyc   <= (CNT_W+1)'(1);
      r_idx   <= '0;
      if (smp_valid) begin
        r_acc   <= w_ext;
        r_peak  <= w_abs;
        r_nsamp <= (CNT_W+1)'(1);
      end else begin
        r_acc   <= '0;
        r_peak  <= '0;
        r_nsamp <= '0;
      end
    end else if (r_state == S_RUN) begin
      if (r_cyc != '1)
        r_cyc <= r_cyc + (CNT_W+1)'(1);
      if (smp_valid) begin
        r_acc  <= r_acc + w_ext;
        r_peak <= w_peak;
        r_idx  <= w_idx;
        if (r_nsamp != '1)
          r_nsamp <= r_nsamp + (CNT_W+1)'(1);
      end
    end
  end

  // result register, handshake and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid    <= 1'b0;
      res_acc      <= '0;
      res_peak     <= '0;
      res_peak_idx <= '0;
      res_nsamp    <= '0;
      res_len_err  <= 1'b0;
      overrun      <= 1'b0;
    end else if (w_close) begin
      res_valid    <= 1'b1;
      res_acc      <= r_acc;
      res_peak     <= r_peak;
      res_peak_idx <= r_idx;
      res_nsamp    <= r_nsamp;
      res_len_err  <= (r_cyc != (CNT_W+1)'(FRAME_LEN));
      if (res_valid && !res_ready)
        overrun <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_collector.sv
// Directed bench for frame_collector.
// Each task drives one scenario and checks its own results.
`timescale 1ns/1ps
module tb_frame_collector;

  logic        clk;
  logic        rst_n;
  logic        frame_rst;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic        res_valid;
  logic        res_ready;
  logic [27:0] res_acc;
  logic [16:0] res_peak;
  logic [11:0] res_peak_idx;
  logic [12:0] res_nsamp;
  logic        res_len_err;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  frame_collector #(
    .DATA_W    (16),
    .FRAME_LEN (2048),
    .CNT_W     (12)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_rst    (frame_rst),
    .smp_valid    (smp_valid),
    .smp_data     (smp_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_acc      (res_acc),
    .res_peak     (res_peak),
    .res_peak_idx (res_peak_idx),
    .res_nsamp    (res_nsamp),
    .res_len_err  (res_len_err),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step(input logic fr, input logic v, input int d);
    frame_rst = fr;
    smp_valid = v;
    smp_data  = 16'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    frame_rst = 1'b0;
    smp_valid = 1'b0;
    smp_data  = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    checks++;
    if ({res_valid, res_acc, res_peak, res_peak_idx,
         res_nsamp, res_len_err, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b acc=%0d ovr=%0b required all 0",
               res_valid, res_acc, overrun);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 50);
      if (res_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait_no_result: got %0d cycles valid required 0", bad);
    end
    step(1'b1, 1'b0, 0);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_boundary: got valid=%0b required 0", res_valid);
    end
    repeat (3) step(1'b0, 1'b1, 1);
    step(1'b1, 1'b0, 0);
    checks++;
    if (res_valid !== 1'b1 || res_acc !== 28'd3 || res_nsamp !== 13'd3) begin
      errors++;
      $display("FAIL wait_discard: got v=%0b acc=%0d n=%0d required 1 3 3",
               res_valid, res_acc, res_nsamp);
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    res_ready = 1'b1;
    step(1'b1, 1'b1, 3);
    repeat (2047) step(1'b0, 1'b1, 3);
    step(1'b1, 1'b1, 3);
    checks++;
    if (res_valid !== 1'b1 || res_acc !== 28'd6144 || res_peak !== 17'd3 ||
        res_peak_idx !== 12'd0 || res_nsamp !== 13'd2048 ||
        res_len_err !== 1'b0) begin
      errors++;
      $display("FAIL full_frame: got v=%0b acc=%0d pk=%0d idx=%0d n=%0d le=%0b required 1 6144 3 0 2048 0",
               res_valid, res_acc, res_peak, res_peak_idx, res_nsamp, res_len_err);
    end
    step(1'b0, 1'b1, 3);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_accept: got valid=%0b required 0", res_valid);
    end
  endtask

  task automatic test_peak_neg();
    logic [27:0] e_acc;
    e_acc = 28'(-65524);
    do_reset();
    step(1'b1, 1'b1, 5);
    step(1'b0, 1'b1, -32768);
    step(1'b0, 1'b1, 7);
    step(1'b0, 1'b1, -32768);
    step(1'b1, 1'b0, 0);
    checks++;
    if (res_peak !== 17'd32768 || res_peak_idx !== 12'd1) begin
      errors++;
      $display("FAIL peak_neg: got pk=%0d idx=%0d required 32768 1",
               res_peak, res_peak_idx);
    end
    checks++;
    if (res_acc !== e_acc || res_nsamp !== 13'd4 || res_len_err !== 1'b1) begin
      errors++;
      $display("FAIL peak_acc: got acc=%0h n=%0d le=%0b required %0h 4 1",
               res_acc, res_nsamp, res_len_err, e_acc);
    end
  endtask

  task automatic test_short_frame();
    do_reset();
    res_ready = 1'b1;
    step(1'b1, 1'b1, 1);
    for (int i = 1; i < 1000; i++)
      step(1'b0, (i % 2) == 0, 1);
    step(1'b1, 1'b0, 0);
    checks++;
    if (res_len_err !== 1'b1 || res_nsamp !== 13'd500 || res_acc !== 28'd500) begin
      errors++;
      $display("FAIL short_frame: got le=%0b n=%0d acc=%0d required 1 500 500",
               res_len_err, res_nsamp, res_acc);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    step(1'b1, 1'b1, 2);
    repeat (3) step(1'b0, 1'b1, 2);
    step(1'b1, 1'b1, -4);
    checks++;
    if (res_valid !== 1'b1 || res_acc !== 28'd8 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: got v=%0b acc=%0d ovr=%0b required 1 8 0",
               res_valid, res_acc, overrun);
    end
    step(1'b0, 1'b1, 9);
    step(1'b0, 1'b1, -1);
    step(1'b1, 1'b0, 0);
    checks++;
    if (overrun !== 1'b1 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_flag: got ovr=%0b v=%0b required 1 1", overrun, res_valid);
    end
    checks++;
    if (res_acc !== 28'd4 || res_peak !== 17'd9 || res_peak_idx !== 12'd1 ||
        res_nsamp !== 13'd3) begin
      errors++;
      $display("FAIL ovr_fields: got acc=%0d pk=%0d idx=%0d n=%0d required 4 9 1 3",
               res_acc, res_peak, res_peak_idx, res_nsamp);
    end
    res_ready = 1'b1;
    step(1'b0, 1'b0, 0);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_accept: got v=%0b ovr=%0b required 0 1", res_valid, overrun);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    res_ready = 1'b1;
    step(1'b1, 1'b1, 10);
    step(1'b1, 1'b1, 20);
    checks++;
    if (res_valid !== 1'b1 || res_acc !== 28'd10 || res_nsamp !== 13'd1) begin
      errors++;
      $display("FAIL b2b_first: got v=%0b acc=%0d n=%0d required 1 10 1",
               res_valid, res_acc, res_nsamp);
    end
    step(1'b1, 1'b1, 30);
    checks++;
    if (res_valid !== 1'b1 || res_acc !== 28'd20 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got v=%0b acc=%0d ovr=%0b required 1 20 0",
               res_valid, res_acc, overrun);
    end
    step(1'b0, 1'b0, 0);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got v=%0b required 0", res_valid);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(1'b1, 1'b1, 7);
    repeat (5) step(1'b0, 1'b1, 7);
    step(1'b1, 1'b1, 7);
    checks++;
    if (res_valid !== 1'b1 || res_acc !== 28'd42 || res_nsamp !== 13'd6) begin
      errors++;
      $display("FAIL mid_pre: got v=%0b acc=%0d n=%0d required 1 42 6",
               res_valid, res_acc, res_nsamp);
    end
    repeat (10) step(1'b0, 1'b1, 7);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, res_acc, res_peak, res_peak_idx,
         res_nsamp, res_len_err, overrun} !== '0) begin
      errors++;
      $display("FAIL mid_async: got v=%0b acc=%0d n=%0d required all 0",
               res_valid, res_acc, res_nsamp);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) step(1'b0, 1'b1, 7);
    step(1'b1, 1'b1, 1);
    repeat (2) step(1'b0, 1'b1, 1);
    step(1'b1, 1'b0, 0);
    checks++;
    if (res_valid !== 1'b1 || res_acc !== 28'd3 || res_nsamp !== 13'd3 ||
        res_peak !== 17'd1 || res_peak_idx !== 12'd0 || res_len_err !== 1'b1) begin
      errors++;
      $display("FAIL mid_clean: got v=%0b acc=%0d n=%0d pk=%0d idx=%0d le=%0b required 1 3 3 1 0 1",
               res_valid, res_acc, res_nsamp, res_peak, res_peak_idx, res_len_err);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_peak_neg();
    test_short_frame();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
